// File: rtl/chip_pkg.sv
// Shared widths, BIST polynomial tap masks, controller state type and step helpers
// for the BIST-wrapped test chip.
package chip_pkg;

   localparam int PI_W = 35;
   localparam int PO_W = 49;

   // Feedback taps: LFSR x^35+x^33+1 (bits 34,32), MISR x^49+x^40+1 (bits 48,39)
   localparam logic [PI_W-1:0] LFSR_TAPS = 35'h5_0000_0000;
   localparam logic [PO_W-1:0] MISR_TAPS = 49'h1_0080_0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } bist_state_t;

   function automatic logic [PI_W-1:0] lfsr_step(input logic [PI_W-1:0] s);
      return {s[PI_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic logic [PO_W-1:0] misr_step(input logic [PO_W-1:0] m,
                                                  input logic [PO_W-1:0] d);
      return {m[PO_W-2:0], ^(m & MISR_TAPS)} ^ d;
   endfunction

endpackage

// File: rtl/chip_bist_ctrl.sv
// BIST controller: IDLE/RUN/DONE sequencing, pattern counter, pattern LFSR and
// response MISR with a registered done/pass verdict.
module chip_bist_ctrl
   import chip_pkg::*;
#(
   parameter int              NUM_PATTERNS = 2000,
   parameter logic [PI_W-1:0] LFSR_SEED    = 35'h1,
   parameter logic [PO_W-1:0] GOLDEN_SIG   = 49'h0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            bistmode,
   input  logic [PO_W-1:0] cut_out,
   output logic            run,
   output logic [PI_W-1:0] pattern,
   output logic            bistdone,
   output logic            bistpass
);

   localparam int              CNT_W    = $clog2(NUM_PATTERNS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

   bist_state_t     state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [PI_W-1:0] lfsr_reg;
   logic [PO_W-1:0] misr_reg;
   logic [PO_W-1:0] misr_next;
   logic            done_reg;
   logic            pass_reg;

   assign misr_next = misr_step(misr_reg, cut_out);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         lfsr_reg  <= LFSR_SEED;
         misr_reg  <= '0;
         done_reg  <= 1'b0;
         pass_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bistmode) begin
                  state_reg <= RUN;
                  cnt_reg   <= '0;
               end
            end
            RUN: begin
               // An abort leaves LFSR and MISR where they are; only reset reseeds them
               if (!bistmode) begin
                  state_reg <= IDLE;
               end else begin
                  lfsr_reg <= lfsr_step(lfsr_reg);
                  misr_reg <= misr_next;
                  cnt_reg  <= cnt_reg + CNT_W'(1);
                  if (cnt_reg == LAST_CNT) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                     pass_reg  <= (misr_next == GOLDEN_SIG);
                  end
               end
            end
            DONE: begin
               if (!bistmode) begin
                  state_reg <= IDLE;
                  done_reg  <= 1'b0;
                  pass_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign run      = (state_reg == RUN);
   assign pattern  = lfsr_reg;
   assign bistdone = done_reg;
   assign bistpass = pass_reg;

endmodule

// File: rtl/chip_cut.sv
// Sequential circuit under test: 35 inputs, 49 outputs, 49 state flops.
// Internal nets n482gat and II282 are kept as named signals so they can be forced.
module chip_cut
   import chip_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [PI_W-1:0] cut_in,
   output logic [PO_W-1:0] cut_out
);

   logic [PO_W-1:0] q_reg;
   logic [PO_W-1:0] q_next;
   logic            n482gat;
   logic            II282;

   assign n482gat = ^(cut_in & q_reg[PI_W-1:0]);
   assign II282   = cut_in[0] | q_reg[PO_W-1];
   assign q_next  = {q_reg[PO_W-2:0], n482gat ^ II282} ^ {cut_in, {(PO_W-PI_W){1'b0}}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_reg <= '0;
      end else begin
         q_reg <= q_next;
      end
   end

   assign cut_out = q_reg ^ {{(PO_W-PI_W){1'b0}}, cut_in};

endmodule

// File: rtl/chip.sv
// Test chip top: CUT instance `circuit`, LFSR/pi input mux and the BIST controller.
// The selected 35-bit source maps bit 34 onto CUT input 0.
module chip
   import chip_pkg::*;
#(
   parameter int              NUM_PATTERNS = 2000,
   parameter logic [PI_W-1:0] LFSR_SEED    = 35'h1,
   parameter logic [PO_W-1:0] GOLDEN_SIG   = 49'h0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PI_W-1:0] pi,
   output logic [PO_W-1:0] po,
   input  logic            bistmode,
   output logic            bistdone,
   output logic            bistpass
);

   logic            run;
   logic [PI_W-1:0] pattern;
   logic [PI_W-1:0] cut_in;
   logic [PO_W-1:0] cut_out;

   generate
      for (genvar gi = 0; gi < PI_W; gi++) begin : g_in_map
         assign cut_in[gi] = run ? pattern[PI_W-1-gi] : pi[PI_W-1-gi];
      end
   endgenerate

   chip_cut circuit (
      .clk     (clk),
      .rst     (rst),
      .cut_in  (cut_in),
      .cut_out (cut_out)
   );

   assign po = cut_out;

   chip_bist_ctrl #(
      .NUM_PATTERNS (NUM_PATTERNS),
      .LFSR_SEED    (LFSR_SEED),
      .GOLDEN_SIG   (GOLDEN_SIG)
   ) bist_ctrl (
      .clk      (clk),
      .rst      (rst),
      .bistmode (bistmode),
      .cut_out  (cut_out),
      .run      (run),
      .pattern  (pattern),
      .bistdone (bistdone),
      .bistpass (bistpass)
   );

endmodule

// File: tb/tb_chip.sv
// Self-checking bench for chip: functional transparency, BIST latency/verdict,
// repeatability, stuck-at detection, reset mid-run and mode abort.
module tb_chip;

   localparam int          NP      = 800;
   localparam logic [34:0] SEED    = 35'h0_1234_5677;
   localparam logic [34:0] PI_BIST = 35'h5_A5C3_3C96;

   // CUT input i takes source bit 34-i
   function automatic logic [34:0] rev35(input logic [34:0] v);
      logic [34:0] r;
      r = '0;
      for (int i = 0; i < 35; i++) r[i] = v[34-i];
      return r;
   endfunction

   // CUT behaviour: state shifts up, new LSB = parity(u & q[34:0]) ^ (u0 | q48),
   // inputs folded into the top 35 state bits; outputs are state ^ inputs.
   function automatic logic [48:0] cut_step(input logic [48:0] q, input logic [34:0] u);
      logic fb;
      fb = (^(u & q[34:0])) ^ (u[0] | q[48]);
      return {q[47:0], fb} ^ {u, 14'h0};
   endfunction

   function automatic logic [48:0] cut_resp(input logic [48:0] q, input logic [34:0] u);
      return q ^ {14'h0, u};
   endfunction

   // Signature after np captures of a fresh run: one IDLE edge with PI_BIST, then np patterns
   function automatic logic [48:0] calc_sig(input int np);
      logic [48:0] q;
      logic [48:0] m;
      logic [34:0] s;
      logic [34:0] u;
      q = cut_step(49'h0, rev35(PI_BIST));
      m = '0;
      s = SEED;
      for (int b = 0; b * 40 < np; b++) begin
         for (int j = 0; j < 40; j++) begin
            if (b * 40 + j < np) begin
               u = rev35(s);
               m = {m[47:0], m[48] ^ m[39]} ^ cut_resp(q, u);
               q = cut_step(q, u);
               s = {s[33:0], s[34] ^ s[32]};
            end
         end
      end
      return m;
   endfunction

   localparam logic [48:0] GOLD = calc_sig(NP);

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        bistmode = 1'b0;
   logic [34:0] pi = '0;
   logic [48:0] po;
   logic        bistdone;
   logic        bistpass;

   int total = 0;
   int bad   = 0;

   chip #(
      .NUM_PATTERNS (NP),
      .LFSR_SEED    (SEED),
      .GOLDEN_SIG   (GOLD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pi       (pi),
      .po       (po),
      .bistmode (bistmode),
      .bistdone (bistdone),
      .bistpass (bistpass)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_bist(input string name, input logic exp_pass, output logic [48:0] sig);
      pi = PI_BIST;
      bistmode = 1'b1;
      do_reset();
      total++;
      if (bistdone !== 1'b0) begin
         bad++;
         $display("FAIL %s done_after_reset: got %b expected 0", name, bistdone);
      end
      for (int e = 1; e <= NP + 1; e++) begin
         @(posedge clk);
         #1;
         if (e == NP) begin
            total++;
            if (bistdone !== 1'b0) begin
               bad++;
               $display("FAIL %s done_early: got %b expected 0 at edge %0d", name, bistdone, e);
            end
         end
      end
      total++;
      if (bistdone !== 1'b1) begin
         bad++;
         $display("FAIL %s done_latency: got %b expected 1 at edge %0d", name, bistdone, NP + 1);
      end
      total++;
      if (bistpass !== exp_pass) begin
         bad++;
         $display("FAIL %s pass: got %b expected %b", name, bistpass, exp_pass);
      end
      sig = dut.bist_ctrl.misr_reg;
      $display("run %s: done=%b pass=%b sig=%h", name, bistdone, bistpass, sig);
   endtask

   task automatic test_reset();
      bistmode = 1'b1;
      pi = 35'($urandom());
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bistdone !== 1'b0 || bistpass !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags: got done=%b pass=%b expected 0 0", bistdone, bistpass);
      end
      total++;
      if (po !== cut_resp(49'h0, rev35(pi))) begin
         bad++;
         $display("FAIL reset_po: got %h expected %h", po, cut_resp(49'h0, rev35(pi)));
      end
      $display("reset: po=%h done=%b pass=%b", po, bistdone, bistpass);
   endtask

   task automatic test_functional();
      logic [48:0] q;
      logic [48:0] exp_po;
      bistmode = 1'b0;
      pi = 35'({$urandom(), $urandom()});
      do_reset();
      q = '0;
      for (int i = 0; i < 24; i++) begin
         pi = 35'({$urandom(), $urandom()});
         #1;
         exp_po = cut_resp(q, rev35(pi));
         total++;
         if (po !== exp_po) begin
            bad++;
            $display("FAIL func_po[%0d]: got %h expected %h", i, po, exp_po);
         end
         total++;
         if (bistdone !== 1'b0) begin
            bad++;
            $display("FAIL func_done[%0d]: got %b expected 0", i, bistdone);
         end
         $display("func %0d: pi=%h po=%h", i, pi, po);
         q = cut_step(q, rev35(pi));
         @(negedge clk);
      end
   endtask

   task automatic test_fault_free();
      logic [48:0] sig;
      run_bist("fault_free", 1'b1, sig);
      total++;
      if (sig !== GOLD) begin
         bad++;
         $display("FAIL fault_free_sig: got %h expected %h", sig, GOLD);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (bistdone !== 1'b1 || bistpass !== 1'b1) begin
            bad++;
            $display("FAIL done_hold[%0d]: got done=%b pass=%b expected 1 1", i, bistdone, bistpass);
         end
      end
      bistmode = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (bistdone !== 1'b0 || bistpass !== 1'b0) begin
         bad++;
         $display("FAIL done_exit: got done=%b pass=%b expected 0 0", bistdone, bistpass);
      end
   endtask

   task automatic test_back_to_back();
      logic [48:0] sig;
      for (int r = 0; r < 3; r++) begin
         run_bist($sformatf("repeat%0d", r), 1'b1, sig);
         total++;
         if (sig !== GOLD) begin
            bad++;
            $display("FAIL repeat%0d_sig: got %h expected %h", r, sig, GOLD);
         end
         rst = 1'b0;
         #1;
         total++;
         if (bistdone !== 1'b0) begin
            bad++;
            $display("FAIL repeat%0d_async_clear: got %b expected 0", r, bistdone);
         end
      end
   endtask

   task automatic test_stuck_at();
      logic [48:0] sig;
      force dut.circuit.n482gat = 1'b0;
      run_bist("sa0_n482gat", 1'b0, sig);
      release dut.circuit.n482gat;
      total++;
      if (sig === GOLD) begin
         bad++;
         $display("FAIL sa0_sig: got %h expected anything but %h", sig, GOLD);
      end
      force dut.circuit.II282 = 1'b1;
      run_bist("sa1_II282", 1'b0, sig);
      release dut.circuit.II282;
      total++;
      if (sig === GOLD) begin
         bad++;
         $display("FAIL sa1_sig: got %h expected anything but %h", sig, GOLD);
      end
      run_bist("post_fault", 1'b1, sig);
   endtask

   task automatic test_reset_mid_run();
      logic [48:0] sig;
      logic [48:0] part;
      pi = PI_BIST;
      bistmode = 1'b1;
      do_reset();
      for (int e = 1; e <= 501; e++) begin
         @(posedge clk);
         #1;
      end
      part = calc_sig(500);
      total++;
      if (dut.bist_ctrl.misr_reg !== part) begin
         bad++;
         $display("FAIL partial_sig: got %h expected %h", dut.bist_ctrl.misr_reg, part);
      end
      rst = 1'b0;
      #1;
      total++;
      if (bistdone !== 1'b0) begin
         bad++;
         $display("FAIL midrun_done: got %b expected 0", bistdone);
      end
      total++;
      if (po !== cut_resp(49'h0, rev35(pi))) begin
         bad++;
         $display("FAIL midrun_po: got %h expected %h", po, cut_resp(49'h0, rev35(pi)));
      end
      total++;
      if (dut.bist_ctrl.lfsr_reg !== SEED || dut.bist_ctrl.misr_reg !== 49'h0) begin
         bad++;
         $display("FAIL midrun_reseed: got lfsr=%h misr=%h expected %h 0",
                  dut.bist_ctrl.lfsr_reg, dut.bist_ctrl.misr_reg, SEED);
      end
      $display("midrun reset: partial=%h", part);
      run_bist("rerun", 1'b1, sig);
      total++;
      if (sig !== GOLD) begin
         bad++;
         $display("FAIL rerun_sig: got %h expected %h", sig, GOLD);
      end
   endtask

   task automatic test_mode_abort();
      logic [34:0] a;
      logic [34:0] b;
      logic [48:0] pa;
      logic [48:0] pb;
      pi = PI_BIST;
      bistmode = 1'b1;
      do_reset();
      for (int e = 1; e <= 300; e++) begin
         @(posedge clk);
         #1;
      end
      a = 35'({$urandom(), $urandom()});
      b = ~a;
      pi = a;
      #1;
      pa = po;
      pi = b;
      #1;
      pb = po;
      total++;
      if (pa !== pb) begin
         bad++;
         $display("FAIL run_ignores_pi: got %h vs %h expected equal", pa, pb);
      end
      bistmode = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (bistdone !== 1'b0) begin
         bad++;
         $display("FAIL abort_done: got %b expected 0", bistdone);
      end
      pi = a;
      #1;
      pa = po;
      pi = b;
      #1;
      pb = po;
      total++;
      if ((pa ^ pb) !== {14'h0, rev35(a) ^ rev35(b)}) begin
         bad++;
         $display("FAIL abort_mux_pi: got %h expected %h", pa ^ pb, {14'h0, rev35(a) ^ rev35(b)});
      end
      $display("abort: done=%b po_delta=%h", bistdone, pa ^ pb);
   endtask

   initial begin
      test_reset();
      test_functional();
      test_fault_free();
      test_back_to_back();
      test_stuck_at();
      test_reset_mid_run();
      test_mode_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
